// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU front end: receiver FSM states, command
// byte layout and the register map the write consumers decode.
package gpu_pkg;

  // Register address width used when a block does not override it.
  localparam int ADDR_W_DEF = 7;

  // Command byte bit that marks a register-write command.
  localparam int CMD_WRITE_BIT = 7;

  // SPI command receiver states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } rx_state_t;

  // Register map seen by the register file and draw logic.
  localparam logic [6:0] REG_CTRL    = 7'h00;
  localparam logic [6:0] REG_STATUS  = 7'h01;
  localparam logic [6:0] REG_COLOR   = 7'h02;
  localparam logic [6:0] REG_X0      = 7'h04;
  localparam logic [6:0] REG_Y0      = 7'h05;
  localparam logic [6:0] REG_X1      = 7'h06;
  localparam logic [6:0] REG_Y1      = 7'h07;
  localparam logic [6:0] REG_DRAW    = 7'h08;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser plus edge detector for one asynchronous SPI pin.
// The level output and the rise/fall strobes leave the same register stage,
// so a strobe and the level seen alongside it always describe the same edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, preset to the pin's idle level.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Edge-detect register: registered level plus single-cycle edge strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= sync_out;
      rise  <= sync_out & ~level;
      fall  <= ~sync_out & level;
    end
  end

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 write-only slave front end. Oversamples sck/mosi/cs in the clk
// domain, assembles bytes MSB-first, decodes command byte + data bytes and
// emits register writes on a valid/ready port.
// Build option: define SPI_RX_AUTOINC_EN for burst writes with address
// auto-increment; without it only the first data byte of a frame is written.
module spi_cmd_rx
  import gpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              cmd_err,
  output logic              ovf
);

  // Synchronised inputs and strobes.
  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_sck),
    .level(sck_level),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_cs),
    .level(cs_level),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_mosi),
    .level(mosi_level),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  // Only the sck rising edge, cs edges and the mosi level drive the design.
  logic unused_strobes;
  assign unused_strobes = ^{sck_level, sck_fall, mosi_rise, mosi_fall};

  // Receiver state.
  rx_state_t         state, state_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [6:0]        shreg;
  logic [ADDR_W-1:0] addr;
  logic              data_seen;     // at least one data byte completed this frame
`ifndef SPI_RX_AUTOINC_EN
  logic              extra_err_done; // surplus-byte error already reported
  logic              extra_err_set;
`endif

  // Per-cycle decisions from the output process.
  logic shift_en, byte_done;
  logic [7:0] rx_byte;
  logic latch_addr, data_byte, load, drop;
  logic cmd_err_nxt, frame_done_nxt;

  // A bit arriving in the same cycle as cs_rise still belongs to the frame,
  // because cs_rise implies cs was low up to this strobe.
  assign shift_en    = sck_rise & (~cs_level | cs_rise);
  assign byte_done   = shift_en & (bit_cnt == 3'd7);
  assign rx_byte     = {shreg, mosi_level};
  assign bit_cnt_nxt = shift_en ? bit_cnt + 3'd1 : bit_cnt;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; cs_rise overrides everything after the byte has
  // been processed.
  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = CMD;
      end
      CMD: begin
        if (byte_done) state_nxt = rx_byte[CMD_WRITE_BIT] ? DATA : DISCARD;
      end
      DATA: begin
`ifndef SPI_RX_AUTOINC_EN
        if (byte_done) state_nxt = DISCARD;
`endif
      end
      DISCARD: begin
        state_nxt = DISCARD;
      end
      default: state_nxt = IDLE;
    endcase
    if (cs_rise) state_nxt = IDLE;
  end

  // FSM output logic: per-cycle actions and next values of the pulse outputs.
  always_comb begin
    latch_addr     = 1'b0;
    data_byte      = 1'b0;
    load           = 1'b0;
    drop           = 1'b0;
    cmd_err_nxt    = 1'b0;
    frame_done_nxt = 1'b0;
`ifndef SPI_RX_AUTOINC_EN
    extra_err_set  = 1'b0;
`endif
    case (state)
      CMD: begin
        if (byte_done) begin
          if (rx_byte[CMD_WRITE_BIT]) latch_addr  = 1'b1;
          else                        cmd_err_nxt = 1'b1;
        end
      end
      DATA: begin
        if (byte_done) begin
          data_byte = 1'b1;
          if (wr_valid && !wr_ready) drop = 1'b1;
          else                       load = 1'b1;
        end
      end
      DISCARD: begin
`ifndef SPI_RX_AUTOINC_EN
        // A surplus byte after a write is reported once per frame.
        if (byte_done && data_seen && !extra_err_done) begin
          cmd_err_nxt   = 1'b1;
          extra_err_set = 1'b1;
        end
`endif
      end
      default: ;
    endcase
    if (cs_rise && state != IDLE) begin
      if (bit_cnt_nxt != 3'd0) cmd_err_nxt = 1'b1;
      if (data_seen || data_byte) frame_done_nxt = 1'b1;
    end
  end

  // Datapath: shift register, address counter, output buffer and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      addr       <= '0;
      data_seen  <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
      ovf        <= 1'b0;
`ifndef SPI_RX_AUTOINC_EN
      extra_err_done <= 1'b0;
`endif
    end else begin
      frame_done <= frame_done_nxt;
      cmd_err    <= cmd_err_nxt;

      if (cs_fall) begin
        bit_cnt   <= 3'd0;
        data_seen <= 1'b0;
      end else begin
        if (shift_en) begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt_nxt;
        end
        if (data_byte) data_seen <= 1'b1;
      end

`ifndef SPI_RX_AUTOINC_EN
      if (cs_fall)            extra_err_done <= 1'b0;
      else if (extra_err_set) extra_err_done <= 1'b1;
`endif

      // Address advances on every data byte, dropped or not.
      if (latch_addr)     addr <= rx_byte[ADDR_W-1:0];
      else if (data_byte) addr <= addr + ADDR_W'(1);

      // Output buffer holds until accepted; a load in the accept cycle
      // replaces the contents and keeps wr_valid high.
      if (load) begin
        wr_valid <= 1'b1;
        wr_addr  <= addr;
        wr_data  <= rx_byte;
      end else if (wr_valid && wr_ready) begin
        wr_valid <= 1'b0;
      end

      if (cs_fall)   ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Self-checking bench for spi_cmd_rx: directed frames from the test plan and
// randomized frames, checked against a frame-level model of expected writes,
// error pulses, frame_done pulses and overflow.
module tb_spi_cmd_rx;

  localparam int ADDR_W = 7;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_sck, spi_mosi, spi_cs;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_done, cmd_err, ovf;

  int total = 0;
  int bad   = 0;

  spi_cmd_rx #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_cs    (spi_cs),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .cmd_err   (cmd_err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected writes, produced by the frame model, consumed on handshakes.
  wr_t exp_q[$];

  // Consumer ready: 0 = random with bounded starvation, 1 = held low, 2 = held high.
  int ready_mode = 2;
  int starve     = 0;
  initial begin
    wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        1: wr_ready = 1'b0;
        2: wr_ready = 1'b1;
        default: begin
          if (starve >= 6 || $urandom_range(0, 3) != 0) begin
            wr_ready = 1'b1;
            starve   = 0;
          end else begin
            wr_ready = 1'b0;
            starve++;
          end
        end
      endcase
    end
  end

  // Compare process: samples mid-cycle, counts pulses, checks each handshake.
  int n_cmd_err = 0;
  int n_frame_done = 0;
  int n_acc = 0;
  logic [ADDR_W-1:0] last_a = '0;
  logic [7:0]        last_d = '0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0) begin
        if (cmd_err === 1'b1)    n_cmd_err++;
        if (frame_done === 1'b1) n_frame_done++;
        if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
          n_acc++;
          last_a = wr_addr;
          last_d = wr_data;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected none", wr_addr, wr_data);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_data", 32'(wr_data), 32'(e.data));
          end
        end
      end
    end
  end

  // Frame-level model: expected writes, error pulses, frame_done, overflow.
  int   exp_err;
  int   exp_fd;
  logic exp_ovf;
  task automatic model_frame(input byte_q_t bytes, input int partial, input bit blocked);
    logic [7:0]        cmd;
    logic [ADDR_W-1:0] a;
    int                nd;
    wr_t               w;
    exp_err = 0;
    exp_fd  = 0;
    exp_ovf = 1'b0;
    if (bytes.size() > 0) begin
      cmd = bytes[0];
      if (!cmd[7]) begin
        exp_err++;
      end else begin
        a  = cmd[ADDR_W-1:0];
        nd = bytes.size() - 1;
        for (int i = 1; i < bytes.size(); i++) begin
          w.addr = a;
          w.data = bytes[i];
`ifdef SPI_RX_AUTOINC_EN
          if (blocked && i > 1) exp_ovf = 1'b1;
          else                  exp_q.push_back(w);
`else
          if (i == 1) exp_q.push_back(w);
`endif
          a = a + 1'b1;
        end
`ifndef SPI_RX_AUTOINC_EN
        if (nd >= 2) exp_err++;
`endif
        if (nd >= 1) exp_fd = 1;
      end
    end
    if (partial > 0) exp_err++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: mosi set while sck low, sampled on the rising edge; clk/8 sck.
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit lat);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      tick(4);
      spi_sck = 1'b1;
      if (lat && i == nbits - 1) begin
        tick(3);
        check("latency_before", 32'(wr_valid), 32'd0);
        tick(1);
        check("latency_at", 32'(wr_valid), 32'd1);
      end else begin
        tick(4);
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input byte_q_t bytes, input int partial,
                           input logic [7:0] pbits, input bit blocked, input bit lat);
    int e0, f0;
    model_frame(bytes, partial, blocked);
    e0 = n_cmd_err;
    f0 = n_frame_done;
    spi_cs = 1'b0;
    tick(4);
    foreach (bytes[i]) send_bits(bytes[i], 8, lat && (i == bytes.size() - 1));
    if (partial > 0) send_bits(pbits, partial, 1'b0);
    tick(4);
    spi_cs = 1'b1;
    tick(12);
    check({tag, "_cmd_err"},    32'(n_cmd_err - e0),    32'(exp_err));
    check({tag, "_frame_done"}, 32'(n_frame_done - f0), 32'(exp_fd));
    check({tag, "_ovf"},        32'(ovf),               32'(exp_ovf));
    if (!blocked) check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t bq;
    int      acc0;

    rst      = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs   = 1'b1;
    tick(4);
    check("rst_wr_valid",   32'(wr_valid),   32'd0);
    check("rst_wr_addr",    32'(wr_addr),    32'd0);
    check("rst_wr_data",    32'(wr_data),    32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_cmd_err",    32'(cmd_err),    32'd0);
    check("rst_ovf",        32'(ovf),        32'd0);
    rst = 1'b0;
    tick(4);

    // Single write with latency check.
    ready_mode = 2;
    acc0 = n_acc;
    bq = {8'h85, 8'h3C};
    run_frame("single", bq, 0, 8'h00, 1'b0, 1'b1);
    check("single_count", 32'(n_acc - acc0), 32'd1);
    check("single_addr",  32'(last_a), 32'h05);
    check("single_data",  32'(last_d), 32'h3C);

    // Burst across the address wrap.
    acc0 = n_acc;
    bq = {8'hFF, 8'h11, 8'h22};
    run_frame("burst", bq, 0, 8'h00, 1'b0, 1'b0);
`ifdef SPI_RX_AUTOINC_EN
    check("burst_count", 32'(n_acc - acc0), 32'd2);
    check("burst_addr",  32'(last_a), 32'h00);
    check("burst_data",  32'(last_d), 32'h22);
`else
    check("burst_count", 32'(n_acc - acc0), 32'd1);
    check("burst_addr",  32'(last_a), 32'h7F);
    check("burst_data",  32'(last_d), 32'h11);
`endif

    // Non-write command.
    acc0 = n_acc;
    bq = {8'h05, 8'hAA};
    run_frame("badcmd", bq, 0, 8'h00, 1'b0, 1'b0);
    check("badcmd_count", 32'(n_acc - acc0), 32'd0);

    // Partial data byte at cs rise.
    acc0 = n_acc;
    bq = {8'h85};
    run_frame("partial", bq, 5, 8'hB0, 1'b0, 1'b0);
    check("partial_count", 32'(n_acc - acc0), 32'd0);

    // Overflow with consumer stalled; next cs fall clears ovf.
    ready_mode = 1;
    tick(2);
    bq = {8'h80, 8'h01, 8'h02};
    run_frame("ovf", bq, 0, 8'h00, 1'b1, 1'b0);
    check("ovf_hold_valid", 32'(wr_valid), 32'd1);
    check("ovf_hold_addr",  32'(wr_addr),  32'h00);
    check("ovf_hold_data",  32'(wr_data),  32'h01);
    spi_cs = 1'b0;
    tick(6);
    check("ovf_cleared", 32'(ovf), 32'd0);
    ready_mode = 2;
    tick(4);
    spi_cs = 1'b1;
    tick(10);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_valid_low", 32'(wr_valid), 32'd0);

    // Reset in the middle of a byte with a write pending.
    ready_mode = 1;
    tick(2);
    spi_cs = 1'b0;
    tick(4);
    send_bits(8'h90, 8, 1'b0);
    send_bits(8'h77, 8, 1'b0);
    send_bits(8'hA5, 3, 1'b0);
    tick(2);
    check("pre_rst_valid", 32'(wr_valid), 32'd1);
    check("pre_rst_addr",  32'(wr_addr),  32'h10);
    check("pre_rst_data",  32'(wr_data),  32'h77);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(wr_valid), 32'd0);
    check("async_rst_addr",  32'(wr_addr),  32'd0);
    check("async_rst_data",  32'(wr_data),  32'd0);
    spi_cs  = 1'b1;
    spi_sck = 1'b0;
    exp_q.delete();
    tick(3);
    rst = 1'b0;
    ready_mode = 2;
    tick(4);
    acc0 = n_acc;
    bq = {8'h81, 8'h55};
    run_frame("post_rst", bq, 0, 8'h00, 1'b0, 1'b0);
    check("post_rst_count", 32'(n_acc - acc0), 32'd1);
    check("post_rst_addr",  32'(last_a), 32'h01);
    check("post_rst_data",  32'(last_d), 32'h55);

    // Randomized frames with a randomly stalling consumer.
    ready_mode = 0;
    for (int f = 0; f < 24; f++) begin
      int         nb;
      int         part;
      logic [7:0] cmd;
      bq.delete();
      cmd = 8'($urandom);
      if ($urandom_range(0, 3) != 0) cmd[7] = 1'b1;
      bq.push_back(cmd);
      nb = $urandom_range(0, 3);
      for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame($sformatf("rnd%0d", f), bq, part, 8'($urandom), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
